// File: rtl/video_pkg.sv
// Shared constants for the character fetch path: geometry, address widths and
// the pixel phases at which each fetch step happens.
package video_pkg;
   localparam int CHAR_W  = 8;
   localparam int MA_W    = 14;
   localparam int CROM_AW = 11;

   localparam logic [2:0] PX_VRAM   = 3'd0;
   localparam logic [2:0] PX_VLATCH = 3'd1;
   localparam logic [2:0] PX_CROM   = 3'd2;
   localparam logic [2:0] PX_GLATCH = 3'd3;
   localparam logic [2:0] PX_LOAD   = 3'd7;

   // ROM address layout: charset select, 7-bit character code, scanline within glyph
   function automatic logic [CROM_AW-1:0] crom_index(input logic graphic,
                                                     input logic [6:0] code,
                                                     input logic [2:0] line);
      return {graphic, code, line};
   endfunction
endpackage

// File: rtl/video_fetch_if.sv
// Display-memory bus between the fetch engine (master) and the video RAM /
// character ROM (slave). Both memories answer one cycle after the address.
interface video_fetch_if;
   import video_pkg::*;

   logic [MA_W-1:0]    vram_addr;
   logic               vram_rd;
   logic [7:0]         vram_data;
   logic [CROM_AW-1:0] crom_addr;
   logic               crom_rd;
   logic [7:0]         crom_data;

   modport master (output vram_addr, vram_rd, crom_addr, crom_rd,
                   input  vram_data, crom_data);
   modport slave  (input  vram_addr, vram_rd, crom_addr, crom_rd,
                   output vram_data, crom_data);
endinterface

// File: rtl/delay_line.sv
// Fixed-length register delay line with synchronous clear; q is d delayed by
// DEPTH clocks.
module delay_line #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] taps [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
      end else begin
         taps[0] <= d;
         for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
      end
   end

   assign q = taps[DEPTH-1];
endmodule

// File: rtl/video_fetch.sv
// Character fetch and pixel serializer: walks MA/RA, reads VRAM then the
// character ROM, and shifts one pixel per clock, one character behind timing.
module video_fetch #(
   parameter int CHAR_W = 8,
   parameter int DELAY  = 8
) (
   input  logic                     pixel_clk,
   input  logic                     reset,
   input  logic                     h_active,
   input  logic                     v_active,
   input  logic                     h_sync,
   input  logic                     v_sync,
   input  logic [video_pkg::MA_W-1:0] start_addr,
   input  logic [7:0]               h_char_displayed,
   input  logic [4:0]               v_char_height,
   input  logic                     graphic,
   video_fetch_if.master            mem,
   output logic                     video,
   output logic                     h_sync_out,
   output logic                     v_sync_out
);
   import video_pkg::*;

   logic [2:0]        px;
   logic              line_ok;
   logic              h_active_q;
   logic              fetch;
   logic [MA_W-1:0]   ma;
   logic [MA_W-1:0]   row_start;
   logic [4:0]        ra;
   logic [7:0]        char_q;
   logic [7:0]        glyph_q;
   logic              inv_q;
   logic              inv;
   logic [CHAR_W-1:0] shift;
   logic              active_d;
   logic [1:0]        sync_d;

   // After a reset the rest of the current line is ignored; fetching restarts
   // only once h_active has been seen low.
   assign fetch = h_active & v_active & line_ok;

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         px         <= '0;
         line_ok    <= 1'b0;
         h_active_q <= 1'b0;
         ma         <= '0;
         row_start  <= '0;
         ra         <= '0;
         char_q     <= '0;
         glyph_q    <= '0;
         inv_q      <= 1'b0;
         inv        <= 1'b0;
         shift      <= '0;
      end else begin
         h_active_q <= h_active;
         if (!h_active) line_ok <= 1'b1;

         if (!h_active || !line_ok) px <= '0;
         else                       px <= px + 3'd1;

         if (!h_active)            ma <= row_start;
         else if (px == PX_LOAD)   ma <= ma + MA_W'(1);

         if (!v_active) begin
            row_start <= start_addr;
            ra        <= '0;
         end else if (h_active_q && !h_active) begin
            if (ra == v_char_height) begin
               ra        <= '0;
               row_start <= row_start + MA_W'(h_char_displayed);
            end else begin
               ra <= ra + 5'd1;
            end
         end

         if (fetch && px == PX_VLATCH) char_q <= mem.vram_data;

         // Scanlines beyond the 8-line glyph are spacing and stay dark.
         if (fetch && px == PX_GLATCH) begin
            glyph_q <= (ra > 5'd7) ? 8'h00 : mem.crom_data;
            inv_q   <= char_q[7];
         end

         if (fetch && px == PX_LOAD) begin
            shift <= CHAR_W'(glyph_q);
            inv   <= inv_q;
         end else begin
            shift <= shift << 1;
         end
      end
   end

   assign mem.vram_addr = ma;
   assign mem.vram_rd   = fetch && (px == PX_VRAM);
   assign mem.crom_rd   = fetch && (px == PX_CROM);
   assign mem.crom_addr = crom_index(graphic, char_q[6:0], ra[2:0]);

   delay_line #(.DEPTH(DELAY), .WIDTH(2)) sync_dl (
      .clk (pixel_clk),
      .rst (reset),
      .d   ({h_sync, v_sync}),
      .q   (sync_d)
   );

   delay_line #(.DEPTH(DELAY), .WIDTH(1)) active_dl (
      .clk (pixel_clk),
      .rst (reset),
      .d   (h_active & v_active),
      .q   (active_d)
   );

   assign {h_sync_out, v_sync_out} = sync_d;
   assign video = (shift[CHAR_W-1] ^ inv) & active_d;
endmodule
